// File: rtl/ws2812_rx_if.sv
// Output bundle of the WS2812 receiver: decoded byte strobe/data, frame-end and error strobes.
// frame_len_out is present only when WS2812_RX_FRAME_LEN_EN is defined.
interface ws2812_rx_if;
  logic        byte_rdy_out;
  logic [7:0]  byte_data_out;
  logic        frame_rdy_out;
  logic        err_out;
`ifdef WS2812_RX_FRAME_LEN_EN
  logic [15:0] frame_len_out;

  modport master (output byte_rdy_out, byte_data_out, frame_rdy_out, err_out, frame_len_out);
  modport slave  (input  byte_rdy_out, byte_data_out, frame_rdy_out, err_out, frame_len_out);
`else
  modport master (output byte_rdy_out, byte_data_out, frame_rdy_out, err_out);
  modport slave  (input  byte_rdy_out, byte_data_out, frame_rdy_out, err_out);
`endif
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 NRZ receiver: classifies high-pulse widths into bits, packs bytes MSB-first and
// detects the latch gap as end of frame. Optional byte count per frame: WS2812_RX_FRAME_LEN_EN.
module ws2812_rx #(
  parameter int BIT_THRESH = 48,
  parameter int MIN_HIGH   = 8,
  parameter int MAX_HIGH   = 120,
  parameter int RST_CYCLES = 4000,
  parameter int CNT_W      = 13
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ws2812_data_in,
  ws2812_rx_if.master rx_if
);

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  // The counter reads (width - 1) on the cycle the ending edge is seen and (samples - 2) while
  // the level persists, so every limit below is pre-shifted to that reference.
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HIGH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(BIT_THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_GAP = CNT_W'(RST_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1);

  logic             sync1_q, sync2_q, hist_q;
  logic             rise, fall, edge_det;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             got_q, got_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic             byte_rdy_q, byte_rdy_d;
  logic             frame_rdy_q, frame_rdy_d;
  logic             err_q, err_d;
  logic             bit_val, width_ok;
`ifdef WS2812_RX_FRAME_LEN_EN
  logic [15:0]      len_q, len_d;
  logic [15:0]      frame_len_q, frame_len_d;
`endif

  assign rise     = sync2_q & ~hist_q;
  assign fall     = ~sync2_q & hist_q;
  assign edge_det = rise | fall;
  assign bit_val  = (cnt_q >= CNT_ONE);
  assign width_ok = (cnt_q >= CNT_MIN) && (cnt_q <= CNT_MAX);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ws2812_data_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      if (edge_det)
        cnt_q <= '0;
      else if (cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + CNT_INC;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    got_d       = got_q;
    byte_data_d = byte_data_q;
    byte_rdy_d  = 1'b0;
    frame_rdy_d = 1'b0;
    err_d       = 1'b0;
`ifdef WS2812_RX_FRAME_LEN_EN
    len_d       = len_q;
    frame_len_d = frame_len_q;
`endif
    case (state_q)
      ST_SYNC: begin
        if (!sync2_q && !edge_det && cnt_q >= CNT_GAP)
          state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (rise)
          state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (fall && width_ok) begin
          shift_d   = {shift_q[6:0], bit_val};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = ST_LOW;
          if (bit_cnt_q == 3'd7) begin
            byte_data_d = {shift_q[6:0], bit_val};
            byte_rdy_d  = 1'b1;
            got_d       = 1'b1;
`ifdef WS2812_RX_FRAME_LEN_EN
            if (len_q != 16'hFFFF)
              len_d = len_q + 16'd1;
`endif
          end
        end else if (fall || cnt_q >= CNT_MAX) begin
          // Bad width or stuck high: abandon the whole frame and resynchronise on a latch gap.
          err_d     = 1'b1;
          shift_d   = '0;
          bit_cnt_d = '0;
          got_d     = 1'b0;
          state_d   = ST_SYNC;
`ifdef WS2812_RX_FRAME_LEN_EN
          len_d     = '0;
`endif
        end
      end
      default: begin
        if (rise) begin
          state_d = ST_HIGH;
        end else if (cnt_q >= CNT_GAP) begin
          frame_rdy_d = got_q;
          err_d       = (bit_cnt_q != 3'd0);
          shift_d     = '0;
          bit_cnt_d   = '0;
          got_d       = 1'b0;
          state_d     = ST_IDLE;
`ifdef WS2812_RX_FRAME_LEN_EN
          if (got_q)
            frame_len_d = len_q;
          len_d = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_SYNC;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      got_q       <= 1'b0;
      byte_data_q <= '0;
      byte_rdy_q  <= 1'b0;
      frame_rdy_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef WS2812_RX_FRAME_LEN_EN
      len_q       <= '0;
      frame_len_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      got_q       <= got_d;
      byte_data_q <= byte_data_d;
      byte_rdy_q  <= byte_rdy_d;
      frame_rdy_q <= frame_rdy_d;
      err_q       <= err_d;
`ifdef WS2812_RX_FRAME_LEN_EN
      len_q       <= len_d;
      frame_len_q <= frame_len_d;
`endif
    end
  end

  assign rx_if.byte_rdy_out  = byte_rdy_q;
  assign rx_if.byte_data_out = byte_data_q;
  assign rx_if.frame_rdy_out = frame_rdy_q;
  assign rx_if.err_out       = err_q;
`ifdef WS2812_RX_FRAME_LEN_EN
  assign rx_if.frame_len_out = frame_len_q;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: table of whole frames plus hand-written error/reset sequences,
// with a byte/frame scoreboard checked whenever the receiver strobes.
module tb_ws2812_rx;
  localparam int MAX_HIGH = 120;
  localparam int GAP      = 4020;
  localparam int NV       = 5;

  typedef struct {
    int              nb;
    logic [2:0][7:0] d;
    int              hi1;
    int              hi0;
    int              extra_bits;
    int              exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [7:0] exp_bytes[$];
  int         exp_lens[$];
  int         exp_len_v;
  int         n_byte = 0, n_frame = 0, n_err = 0;
  int         err_cyc = -1, frame_cyc = -1, fall_cyc = 0;
  logic       prev_b = 1'b0, prev_f = 1'b0, prev_e = 1'b0;
  vec_t       vec[NV];

  ws2812_rx_if rx_if();

  ws2812_rx dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .ws2812_data_in (line),
    .rx_if          (rx_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard side: compare every strobe against what the driver queued.
  always @(negedge clk) begin
    if (rx_if.byte_rdy_out) begin
      n_byte++;
      check("byte_pulse_width", prev_b, 0);
      if (exp_bytes.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL byte_unexpected: got 0x%02h, none queued", rx_if.byte_data_out);
      end else begin
        check("byte_data", rx_if.byte_data_out, exp_bytes.pop_front());
        check("byte_latency", cyc - fall_cyc, 3);
      end
    end
    if (rx_if.frame_rdy_out) begin
      n_frame++;
      frame_cyc = cyc;
      check("frame_pulse_width", prev_f, 0);
      if (exp_lens.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL frame_unexpected: got frame_rdy at cycle %0d, none queued", cyc);
      end else begin
        exp_len_v = exp_lens.pop_front();
`ifdef WS2812_RX_FRAME_LEN_EN
        check("frame_len", rx_if.frame_len_out, exp_len_v);
`endif
      end
    end
    if (rx_if.err_out) begin
      n_err++;
      err_cyc = cyc;
      check("err_pulse_width", prev_e, 0);
    end
    prev_b = rx_if.byte_rdy_out;
    prev_f = rx_if.frame_rdy_out;
    prev_e = rx_if.err_out;
  end

  task automatic hold(input logic v, input int n);
    line = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int hi1, input int hi0);
    int hi;
    hi = b ? hi1 : hi0;
    hold(1'b1, hi);
    fall_cyc = cyc;
    hold(1'b0, (hi < 70) ? 100 - hi : 40);
  endtask

  task automatic send_byte(input logic [7:0] d, input int hi1, input int hi0, input bit push);
    if (push) exp_bytes.push_back(d);
    for (int i = 7; i >= 0; i--) send_bit(d[i], hi1, hi0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_byte_rdy"}, rx_if.byte_rdy_out, 0);
    check({tag, "_byte_data"}, rx_if.byte_data_out, 0);
    check({tag, "_frame_rdy"}, rx_if.frame_rdy_out, 0);
    check({tag, "_err"}, rx_if.err_out, 0);
`ifdef WS2812_RX_FRAME_LEN_EN
    check({tag, "_frame_len"}, rx_if.frame_len_out, 0);
`endif
  endtask

  initial begin
    int b0, f0, e0, rise_cyc;
    vec[0] = '{1, {8'h00, 8'h00, 8'hA5}, 64, 24, 0, 0};
    vec[1] = '{3, {8'h3C, 8'hFF, 8'h00}, 64, 24, 0, 0};
    vec[2] = '{2, {8'h00, 8'h81, 8'h5A}, 48, 47, 0, 0};
    vec[3] = '{1, {8'h00, 8'h00, 8'hC3}, 120, 8, 0, 0};
    vec[4] = '{1, {8'h00, 8'h00, 8'h6E}, 64, 24, 4, 1};

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    hold(1'b0, GAP);

    for (int r = 0; r < NV; r++) begin
      b0 = n_byte; f0 = n_frame; e0 = n_err;
      for (int k = 0; k < vec[r].nb; k++) send_byte(vec[r].d[k], vec[r].hi1, vec[r].hi0, 1'b1);
      for (int k = 0; k < vec[r].extra_bits; k++) send_bit(k[0], vec[r].hi1, vec[r].hi0);
      exp_lens.push_back(vec[r].nb);
      hold(1'b0, GAP);
      check("row_bytes", n_byte - b0, vec[r].nb);
      check("row_frames", n_frame - f0, 1);
      check("row_errs", n_err - e0, vec[r].exp_err);
      check("row_held_byte", rx_if.byte_data_out, vec[r].d[vec[r].nb - 1]);
      if (vec[r].exp_err != 0) check("row_err_with_frame", err_cyc, frame_cyc);
    end

    // Glitch mid-byte: error, then silence until a full latch gap, then clean decode.
    b0 = n_byte; f0 = n_frame; e0 = n_err;
    for (int k = 0; k < 3; k++) send_bit(1'b1, 64, 24);
    hold(1'b1, 5);
    hold(1'b0, 95);
    send_byte(8'h77, 64, 24, 1'b0);
    hold(1'b0, GAP);
    send_byte(8'h96, 64, 24, 1'b1);
    exp_lens.push_back(1);
    hold(1'b0, GAP);
    check("glitch_bytes", n_byte - b0, 1);
    check("glitch_frames", n_frame - f0, 1);
    check("glitch_errs", n_err - e0, 1);

    // Line stuck high.
    b0 = n_byte; f0 = n_frame; e0 = n_err;
    rise_cyc = cyc;
    hold(1'b1, 500);
    hold(1'b0, GAP);
    check("stuck_errs", n_err - e0, 1);
    check("stuck_err_time", err_cyc - rise_cyc, MAX_HIGH + 3);
    check("stuck_bytes", n_byte - b0, 0);
    check("stuck_frames", n_frame - f0, 0);

    // Reset in the middle of a byte, traffic resumes without a gap.
    b0 = n_byte; f0 = n_frame; e0 = n_err;
    for (int k = 0; k < 5; k++) send_bit(1'b1, 64, 24);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("midrst");
    rst = 1'b0;
    send_byte(8'h12, 64, 24, 1'b0);
    send_byte(8'h34, 64, 24, 1'b0);
    hold(1'b0, GAP);
    check("rst_nothing_bytes", n_byte - b0, 0);
    check("rst_nothing_errs", n_err - e0, 0);
    send_byte(8'h12, 64, 24, 1'b1);
    send_byte(8'h34, 64, 24, 1'b1);
    exp_lens.push_back(2);
    hold(1'b0, GAP);
    check("rst_bytes", n_byte - b0, 2);
    check("rst_frames", n_frame - f0, 1);
    check("rst_errs", n_err - e0, 0);

    check("bytes_left", exp_bytes.size(), 0);
    check("frames_left", exp_lens.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
